// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: imem request/response plus decode-side instruction and control signals.
// With IFU_ALIGN_CHECK_EN defined the bundle also carries misalign_err.
interface instr_fetch_if #(parameter int n = 32);
  logic          imem_req;
  logic [n-1:0]  imem_addr;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic [n-1:0]  pc_out;
  logic [1:0]    jump;
  logic          branch;
  logic          branch_taken;
  logic [n-1:0]  jr_addr;
  logic [15:0]   fetch_count;
  logic [1:0]    state_dbg;
`ifdef IFU_ALIGN_CHECK_EN
  logic          misalign_err;
`endif

  // Handshakes: imem_req is held with a stable imem_addr until imem_rvalid is seen in WAIT;
  // an instruction moves to decode on a cycle where instr_valid & instr_ready are both high.
  modport master (
    output imem_req, imem_addr, instr, instr_valid, op, funct, pc_out, fetch_count, state_dbg,
`ifdef IFU_ALIGN_CHECK_EN
    output misalign_err,
`endif
    input  imem_rvalid, imem_rdata, instr_ready, jump, branch, branch_taken, jr_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, op, funct, pc_out, fetch_count, state_dbg,
`ifdef IFU_ALIGN_CHECK_EN
    input  misalign_err,
`endif
    output imem_rvalid, imem_rdata, instr_ready, jump, branch, branch_taken, jr_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: fetch, hold for decode, compute next PC on transfer.
// Optional IFU_ALIGN_CHECK_EN: flag misaligned next PC and halt fetch instead of forcing alignment.
module instr_fetch #(
  parameter int          n        = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  state_t        state_q;
  logic [n-1:0]  pc_q;
  logic          imem_req_q;
  logic [n-1:0]  imem_addr_q;
  logic [31:0]   instr_q;
  logic          instr_valid_q;
  logic [n-1:0]  pc_out_q;
  logic [15:0]   fetch_count_q;
`ifdef IFU_ALIGN_CHECK_EN
  logic          misalign_q;
`endif

  logic [n-1:0]  pc4;
  logic [n-1:0]  br_off;
  logic [n-1:0]  next_raw;
  logic [n-1:0]  next_pc_d;
  logic          transfer;

  assign transfer = instr_valid_q & bus.instr_ready;
  assign pc4      = pc_out_q + n'(4);
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump wins over branch; jump==11 falls through to the sequential/branch path.
  always_comb begin
    next_raw = pc4;
    case (bus.jump)
      2'b01:   next_raw = {pc4[n-1:n-4], instr_q[25:0], 2'b00};
      2'b10:   next_raw = bus.jr_addr;
      default: next_raw = (bus.branch && bus.branch_taken) ? (pc4 + br_off) : pc4;
    endcase
  end

`ifdef IFU_ALIGN_CHECK_EN
  assign next_pc_d = next_raw;
`else
  assign next_pc_d = next_raw & ~{{(n-2){1'b0}}, 2'b11};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      pc_out_q      <= RESET_PC;
      fetch_count_q <= 16'h0;
`ifdef IFU_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= WAIT;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            instr_q       <= bus.imem_rdata;
            pc_out_q      <= pc_q;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (transfer) begin
            pc_q          <= next_pc_d;
            instr_valid_q <= 1'b0;
            fetch_count_q <= fetch_count_q + 16'd1;
`ifdef IFU_ALIGN_CHECK_EN
            // A misaligned target parks the unit in HOLD with nothing valid until reset.
            if (next_pc_d[1:0] != 2'b00) begin
              misalign_q <= 1'b1;
              state_q    <= HOLD;
              imem_req_q <= 1'b0;
            end else begin
              imem_req_q  <= 1'b1;
              imem_addr_q <= next_pc_d;
              state_q     <= WAIT;
            end
`else
            imem_req_q  <= 1'b1;
            imem_addr_q <= next_pc_d;
            state_q     <= WAIT;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.op          = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.pc_out      = pc_out_q;
  assign bus.fetch_count = fetch_count_q;
  assign bus.state_dbg   = state_q;
`ifdef IFU_ALIGN_CHECK_EN
  assign bus.misalign_err = misalign_q;
`endif
endmodule
